// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Div-by-zero skips the iterations and returns the RISC-V defined result.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [2*XLEN-1:0] p_q, p_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   res_q, res_d;

  // Operand signedness and magnitudes at the accept edge.
  logic            sgn1, sgn2, s1_neg, s2_neg, div_zero;
  logic [XLEN-1:0] mag1, mag2;

  assign sgn1     = funct3_i[2] ? ~funct3_i[0] : (funct3_i != 3'b011);
  assign sgn2     = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
  assign s1_neg   = sgn1 & src1_i[XLEN-1];
  assign s2_neg   = sgn2 & src2_i[XLEN-1];
  assign mag1     = s1_neg ? -src1_i : src1_i;
  assign mag2     = s2_neg ? -src2_i : src2_i;
  assign div_zero = funct3_i[2] && (src2_i == '0);

  // p_q holds {hi, lo}: for multiply the running product with the multiplier
  // shifting out of lo; for divide {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_step, div_step, p_fin, prod;
  logic [XLEN-1:0]   quot, rem, res_calc;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : '0);
    mul_step = {mul_sum, p_q[XLEN-1:1]};
    div_sh   = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_ge   = div_sh >= {1'b0, a_q};
    div_diff = div_sh - {1'b0, a_q};
    div_step = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), p_q[XLEN-2:0], div_ge};
    p_fin    = dz_q ? p_q : (op_q[2] ? div_step : mul_step);
    prod     = neg_q ? -p_fin : p_fin;
    quot     = neg_q ? -p_fin[XLEN-1:0] : p_fin[XLEN-1:0];
    rem      = neg_rem_q ? -p_fin[2*XLEN-1:XLEN] : p_fin[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:          res_calc = prod[XLEN-1:0];
      3'b100, 3'b101:  res_calc = quot;
      3'b110, 3'b111:  res_calc = rem;
      default:         res_calc = prod[2*XLEN-1:XLEN];
    endcase
  end

  // NOTE: every signal gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    p_d       = p_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    res_d     = res_q;
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_d = CALC;
          op_d    = funct3_i;
          dz_d    = div_zero;
          if (div_zero) begin
            // Single pass through CALC keeps div-by-zero at two cycles of latency.
            cnt_d     = '0;
            a_d       = '0;
            p_d       = {src1_i, {XLEN{1'b1}}};
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            cnt_d     = CW'(XLEN - 1);
            a_d       = mag2;
            p_d       = {{XLEN{1'b0}}, mag1};
            neg_d     = s1_neg ^ s2_neg;
            neg_rem_d = s1_neg;
          end
        end
        CALC: begin
          p_d   = p_fin;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE;
            res_d   = res_calc;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      p_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      p_q       <= p_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      res_q     <= res_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign result_o = res_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: hand-computed RV32M results, latency, kill, reset
// and start-while-busy behaviour.
module tb_mdu_iter;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, kill_i;
  logic [2:0]  funct3_i;
  logic [31:0] src1_i, src2_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  mdu_iter #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .kill_i   (kill_i),
    .funct3_i (funct3_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle request; returns at the negedge after the accept edge.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    start_i  = 1'b1;
    funct3_i = f;
    src1_i   = a;
    src2_i   = b;
    @(negedge clk_i);
    start_i  = 1'b0;
    src1_i   = '0;
    src2_i   = '0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk_i);
      if (done_o) cnt++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(f, a, b);
    wait_done(lat);
    check({tag, " lat"}, lat, exp_lat);
    check({tag, " res"}, result_o, exp);
    @(negedge clk_i);
    check({tag, " busy_after"}, {31'b0, busy_o}, 32'd0);
    check({tag, " done_pulse"}, {31'b0, done_o}, 32'd0);
    last_res = exp;
  endtask

  initial begin
    int lat, n;
    rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0;
    funct3_i = '0; src1_i = '0; src2_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst busy", {31'b0, busy_o}, 32'd0);
    check("rst done", {31'b0, done_o}, 32'd0);
    check("rst result", result_o, 32'd0);
    rst_i = 1'b0;

    run("mul_7x6",      MUL,    32'd7,        32'd6,        32'h0000002A, 32);
    run("mul_m1xm1",    MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32);
    run("mulh_m1xm1",   MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32);
    run("mulhu_max",    MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
    run("mulhsu_m1x2",  MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32);
    run("mulh_min2",    MULH,   32'h80000000, 32'h80000000, 32'h40000000, 32);
    run("div_m7_2",     DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32);
    run("rem_m7_2",     REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32);
    run("div_7_m2",     DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32);
    run("rem_7_m2",     REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 32);
    run("div_ovf",      DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32);
    run("rem_ovf",      REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32);
    run("divu_100_7",   DIVU,   32'd100,      32'd7,        32'h0000000E, 32);
    run("remu_100_7",   REMU,   32'd100,      32'd7,        32'h00000002, 32);
    run("divu_by0",     DIVU,   32'h12345678, 32'd0,        32'hFFFFFFFF, 1);
    run("remu_by0",     REMU,   32'h12345678, 32'd0,        32'h12345678, 1);
    run("div_by0",      DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1);
    run("rem_by0",      REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);

    // Kill mid-MUL: back to idle, no done, result held.
    start_op(MUL, 32'd5, 32'd5);
    repeat (9) @(negedge clk_i);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    check("kill busy", {31'b0, busy_o}, 32'd0);
    count_dones(40, n);
    check("kill no_done", n, 32'd0);
    check("kill result_held", result_o, last_res);
    run("after_kill", MUL, 32'd9, 32'd9, 32'h00000051, 32);

    // Kill together with start in IDLE: nothing accepted.
    @(negedge clk_i);
    start_i = 1'b1; kill_i = 1'b1; funct3_i = MUL; src1_i = 32'd2; src2_i = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0; kill_i = 1'b0;
    check("kill_start busy", {31'b0, busy_o}, 32'd0);
    count_dones(40, n);
    check("kill_start no_done", n, 32'd0);
    check("kill_start result", result_o, last_res);

    // Start while busy is ignored.
    start_op(MUL, 32'd3, 32'd4);
    repeat (5) @(negedge clk_i);
    start_i = 1'b1; funct3_i = DIVU; src1_i = 32'd100; src2_i = 32'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(lat);
    check("busy_start lat", lat, 32'd26);
    check("busy_start res", result_o, 32'h0000000C);
    count_dones(40, n);
    check("busy_start no_extra", n, 32'd0);

    // Reset mid-DIV.
    start_op(DIV, 32'd100, 32'd7);
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst busy", {31'b0, busy_o}, 32'd0);
    check("midrst result", result_o, 32'd0);
    count_dones(40, n);
    check("midrst no_done", n, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
